velocity_mem_ctrl: RTL and testbench

Sequencer and port arbiter for one single-port velocity cell memory (M20K, 1-cycle read latency; address 0 holds the particle count, addresses 1..N hold {vz,vy,vx}). On start it reads the count, then streams every particle velocity to the motion-update datapath. It merges write-back of updated velocities onto the same port, giving writes priority.

---
 rtl/velocity_mem_ctrl_pkg.sv | 20 ++
 rtl/velocity_rd_tag_pipe.sv | 38 +++
 rtl/velocity_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_velocity_mem_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/velocity_mem_ctrl_pkg.sv
// Shared definitions for the velocity cell memory controllers: velocity word
// layout {vz,vy,vx} and sequencer state encodings.
package velocity_mem_ctrl_pkg;

  localparam int FLOAT_WIDTH    = 32;
  localparam int VX_LSB         = 0;
  localparam int VY_LSB         = FLOAT_WIDTH;
  localparam int VZ_LSB         = 2 * FLOAT_WIDTH;
  localparam int VEL_WORD_WIDTH = 3 * FLOAT_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CNT   = 3'd1,
    ST_WAIT_CNT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } vmc_state_e;

endpackage

// File: rtl/velocity_rd_tag_pipe.sv
// Valid+address delay line matching the memory read latency, so each returned
// word can be tagged with the address it was read from.
module velocity_rd_tag_pipe #(
  parameter int DEPTH      = 1,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  output logic                  out_valid_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o
);

  logic [DEPTH-1:0]      vld_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  // Shift register of read tags; reset drops every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_valid_i;
      addr_q[0] <= in_addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/velocity_mem_ctrl.sv
// Sweep sequencer and write-priority port arbiter for the single-port
// velocity cell memory (address 0 = particle count, 1..N = velocities).
module velocity_mem_ctrl
  import velocity_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = VEL_WORD_WIDTH,
  parameter int PARTICLE_NUM   = 220,
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int                    LAT_W    = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(MEM_RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

  vmc_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  wr_err_q, wr_err_d;

  logic                  sweep_s;
  logic                  start_acc_s;
  logic                  wr_legal_s;
  logic                  wr_illegal_s;
  logic                  rd_req_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic                  tag_push_s;
  logic [ADDR_WIDTH-1:0] cnt_raw_s;
  logic [ADDR_WIDTH-1:0] cnt_clamp_s;

  assign sweep_s      = (state_q != ST_IDLE);
  assign start_acc_s  = (state_q == ST_IDLE) && start;
  // While sweeping, writes beyond the captured count would target words not in this sweep.
  assign wr_legal_s   = wr_valid && (wr_addr != '0) && (wr_addr <= MAX_ADDR) &&
                        (!sweep_s || (wr_addr <= count_q));
  assign wr_illegal_s = wr_valid && !wr_legal_s;
  assign cnt_raw_s    = mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamp_s  = (cnt_raw_s > MAX_ADDR) ? MAX_ADDR : cnt_raw_s;
  assign wr_err_d     = wr_illegal_s ? 1'b1 : (start_acc_s ? 1'b0 : wr_err_q);

  // Next-state logic; any read request is held in place while a write owns the port.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    lat_d      = lat_q;
    rd_req_s   = 1'b0;
    rd_addr_s  = '0;
    tag_push_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD_CNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_CNT: begin
        rd_req_s = 1'b1;
        if (!wr_legal_s) begin
          state_d = ST_WAIT_CNT;
          lat_d   = '0;
        end else begin
          state_d = ST_RD_CNT;
        end
      end
      ST_WAIT_CNT: begin
        if (lat_q == LAT_LAST) begin
          count_d = cnt_clamp_s;
          if (cnt_clamp_s == '0) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ADDR_WIDTH'(1);
            state_d = ST_STREAM;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_STREAM: begin
        rd_req_s  = 1'b1;
        rd_addr_s = ptr_q;
        if (!wr_legal_s) begin
          tag_push_s = 1'b1;
          ptr_d      = ptr_q + ADDR_WIDTH'(1);
          if (ptr_q == count_q) begin
            state_d = ST_DRAIN;
            lat_d   = '0;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (lat_q == LAT_LAST) begin
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, pointer, captured count and sticky write error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      lat_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      lat_q    <= lat_d;
      wr_err_q <= wr_err_d;
    end
  end

  velocity_rd_tag_pipe #(
    .DEPTH      (MEM_RD_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst),
    .in_valid_i  (tag_push_s),
    .in_addr_i   (ptr_q),
    .out_valid_o (out_valid),
    .out_addr_o  (out_addr)
  );

  assign mem_wren       = wr_legal_s;
  assign mem_rden       = rd_req_s && !wr_legal_s;
  assign mem_address    = wr_legal_s ? wr_addr : rd_addr_s;
  assign mem_data       = wr_data;
  assign out_data       = mem_q;
  assign busy           = sweep_s;
  assign done           = (state_q == ST_DONE);
  assign particle_count = count_q;
  assign wr_err         = wr_err_q;

endmodule

// File: tb/tb_velocity_mem_ctrl.sv
// Self-checking bench for velocity_mem_ctrl: behavioural RAM, shadow velocity
// model and directed sweeps with randomized data.
module tb_velocity_mem_ctrl;
  import velocity_mem_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  particle_count;
  logic        out_valid;
  logic [7:0]  out_addr;
  logic [95:0] out_data;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [95:0] wr_data;
  logic        wr_err;
  logic [7:0]  mem_address;
  logic [95:0] mem_data;
  logic        mem_rden;
  logic        mem_wren;
  logic [95:0] mem_q;

  logic [95:0] ram [256];
  logic [95:0] ref_mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [95:0] bd_data;

  int errors = 0;
  int checks = 0;

  velocity_mem_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .out_valid(out_valid), .out_addr(out_addr),
    .out_data(out_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .mem_address(mem_address), .mem_data(mem_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one cycle read latency; bd_* is a bench-only load path.
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) mem_q <= ram[mem_address];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] rand_vel();
    logic [95:0] w;
    w = '0;
    w[VX_LSB +: FLOAT_WIDTH] = $urandom;
    w[VY_LSB +: FLOAT_WIDTH] = $urandom;
    w[VZ_LSB +: FLOAT_WIDTH] = $urandom;
    return w;
  endfunction

  task automatic bd_write(input logic [7:0] a, input logic [95:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic set_count(input logic [7:0] c);
    logic [95:0] w;
    w = rand_vel();
    w[7:0] = c;
    bd_write(8'd0, w);
  endtask

  // One sweep: n = expected clamped count, optional write at cycle wr_off, optional extra start at st_off.
  task automatic sweep(input int n, input int wr_off, input logic [7:0] wr_a,
                       input logic [95:0] wr_d, input int st_off);
    int          ov_c [$];
    logic [7:0]  ov_a [$];
    logic [95:0] ov_d [$];
    int          done_c, wren_cnt, busy_bad, t_i, exp_done;
    bit          legal;
    logic [95:0] exp_d;
    legal = (wr_off > 0) && (wr_a >= 8'd1) && (wr_a <= 8'd219) && (int'(wr_a) <= n);
    done_c = -1; wren_cnt = 0; busy_bad = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 300 && done_c < 0; c++) begin
      @(posedge clk); #1;
      start    = (c == st_off);
      wr_valid = (c == wr_off);
      wr_addr  = wr_a;
      wr_data  = wr_d;
      #1;
      if (c == 1) begin
        chk("cnt_read", {mem_rden, mem_wren, mem_address}, {1'b1, 1'b0, 8'd0});
        chk("wr_err_clr", wr_err, 1'b0);
      end
      if (busy !== 1'b1) busy_bad++;
      if (mem_wren === 1'b1) wren_cnt++;
      if (out_valid === 1'b1) begin
        ov_c.push_back(c); ov_a.push_back(out_addr); ov_d.push_back(out_data);
      end
      if (done === 1'b1) done_c = c;
    end
    start = 1'b0; wr_valid = 1'b0;
    exp_done = (n == 0) ? 3 : 2 + n + ((legal && wr_off <= 2 + n) ? 1 : 0) + 2;
    chk("done_cycle", done_c, exp_done);
    chk("pcount", particle_count, n);
    chk("n_out", ov_c.size(), n);
    chk("n_wren", wren_cnt, legal ? 1 : 0);
    chk("busy_during", busy_bad, 0);
    for (int i = 1; i <= n && i <= ov_c.size(); i++) begin
      t_i   = 2 + i + ((legal && wr_off <= 2 + i) ? 1 : 0);
      exp_d = (legal && int'(wr_a) == i && wr_off < t_i) ? wr_d : ref_mem[i];
      chk("out_addr", ov_a[i-1], i);
      chk("out_cycle", ov_c[i-1], t_i + 1);
      chk("out_data", ov_d[i-1], exp_d);
    end
    if (legal) ref_mem[wr_a] = wr_d;
    chk("wr_err_end", wr_err, (wr_off > 0 && !legal) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    chk("idle_after", {busy, done, out_valid}, 3'b000);
  endtask

  initial begin
    logic [95:0] d;
    bit ov_seen;
    rst = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, done, out_valid, wr_err, mem_rden, mem_wren}, 6'd0);
    chk("rst_regs", {particle_count, out_addr}, 16'd0);
    for (int a = 1; a < 256; a++) begin
      d = rand_vel();
      ref_mem[a] = d;
      bd_write(a[7:0], d);
    end
    rst = 1'b1;
    set_count(8'd3);

    sweep(3, 0, 8'd0, '0, 0);
    sweep(3, 4, 8'd2, rand_vel(), 0);
    sweep(3, 4, 8'd5, rand_vel(), 4);

    // Idle writes: addresses 0 and 220 are illegal, 10 is legal.
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 8'd0; wr_data = rand_vel(); #1;
    chk("idle_wr0_wren", mem_wren, 1'b0);
    @(posedge clk); #1;
    wr_addr = 8'd220; #1;
    chk("idle_wr220_wren", mem_wren, 1'b0);
    chk("wr_err_sticky", wr_err, 1'b1);
    @(posedge clk); #1;
    d = rand_vel();
    wr_addr = 8'd10; wr_data = d; #1;
    chk("idle_wr10", {mem_wren, mem_rden, mem_address}, {1'b1, 1'b0, 8'd10});
    ref_mem[10] = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("wr_err_hold", wr_err, 1'b1);

    set_count(8'd250);
    sweep(219, 0, 8'd0, '0, 0);
    set_count(8'd0);
    sweep(0, 0, 8'd0, '0, 0);

    // Reset in the middle of a streaming sweep.
    set_count(8'd219);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_stream", {busy, out_valid}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {busy, done, out_valid, wr_err, mem_rden, mem_wren}, 6'd0);
    chk("mid_rst_regs", {particle_count, out_addr}, 16'd0);
    ov_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      ov_seen = ov_seen | out_valid | busy;
    end
    chk("rst_quiet", ov_seen, 1'b0);
    set_count(8'd3);
    #2 rst = 1'b1;
    sweep(3, 0, 8'd0, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
